// File: rtl/regfile_scoreboard_if.sv
// Issue / writeback / status bundle between decode and the register-file hazard scoreboard.
// master = decode side (drives issue and writeback), slave = scoreboard.
interface regfile_scoreboard_if #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int CNT_W    = 3
);
   logic                issue_valid;
   logic                issue_ready;
   logic [ADDR_W-1:0]   issue_rs1;
   logic [ADDR_W-1:0]   issue_rs2;
   logic                issue_uses_rs1;
   logic                issue_uses_rs2;
   logic [ADDR_W-1:0]   issue_rd;
   logic                issue_writes_rd;
   logic                wb_valid;
   logic [ADDR_W-1:0]   wb_rd;
   logic                flush;
   logic [NUM_REGS-1:0] busy_mask;
   logic [CNT_W-1:0]    inflight_count;
   logic [1:0]          stall_cause;
   logic                wb_error;

   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_uses_rs1, issue_uses_rs2,
             issue_rd, issue_writes_rd, wb_valid, wb_rd, flush,
      input  issue_ready, busy_mask, inflight_count, stall_cause, wb_error
   );

   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_uses_rs1, issue_uses_rs2,
             issue_rd, issue_writes_rd, wb_valid, wb_rd, flush,
      output issue_ready, busy_mask, inflight_count, stall_cause, wb_error
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the integer register file: stalls issue on RAW/WAW/capacity
// hazards, clears on writeback, and drops all tracking on flush or reset.
module regfile_scoreboard #(
   parameter int NUM_REGS     = 32,
   parameter int ADDR_W       = 5,
   parameter int MAX_INFLIGHT = 4,
   parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   regfile_scoreboard_if.slave   sb
);
   logic [NUM_REGS-1:0] r_busy;
   logic [CNT_W-1:0]    r_count;
   logic                r_wb_error;

   logic [NUM_REGS-1:0] w_busy;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic                w_raw, w_waw, w_full, w_wr_track;
   logic                w_ready, w_set, w_wb_hit, w_wb_bad, w_wb_nz;
   logic [CNT_W-1:0]    w_count_nxt;

   // Register 0 can never look busy, so it never produces a hazard.
   assign w_busy = {r_busy[NUM_REGS-1:1], 1'b0};

   assign w_wr_track = sb.issue_writes_rd && (sb.issue_rd != '0);
   assign w_raw      = (sb.issue_uses_rs1 && w_busy[sb.issue_rs1]) ||
                       (sb.issue_uses_rs2 && w_busy[sb.issue_rs2]);
   assign w_waw      = w_wr_track && w_busy[sb.issue_rd];
   assign w_full     = w_wr_track && (r_count == CNT_W'(MAX_INFLIGHT));
   assign w_ready    = !sb.flush && !w_raw && !w_waw && !w_full;
   assign w_set      = sb.issue_valid && w_ready && w_wr_track;

   // Writebacks see the pre-edge busy bits: no same-cycle bypass into issue.
   assign w_wb_nz  = sb.wb_valid && !sb.flush && (sb.wb_rd != '0);
   assign w_wb_hit = w_wb_nz && w_busy[sb.wb_rd];
   assign w_wb_bad = w_wb_nz && !w_busy[sb.wb_rd];

   always_comb begin
      sb.stall_cause = 2'd0;
      if (sb.issue_valid && !w_ready && !sb.flush) begin
         if (w_raw)      sb.stall_cause = 2'd1;
         else if (w_waw) sb.stall_cause = 2'd2;
         else            sb.stall_cause = 2'd3;
      end
   end

   // Per-register next state; a set on the same register as a clear wins.
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_busy
      if (g == 0) begin : g_zero
         assign w_busy_nxt[g] = 1'b0;
      end else begin : g_reg
         assign w_busy_nxt[g] =
            (w_set && (sb.issue_rd == ADDR_W'(g))) ||
            (w_busy[g] && !(w_wb_hit && (sb.wb_rd == ADDR_W'(g))));
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      if (w_set && !w_wb_hit)      w_count_nxt = r_count + CNT_W'(1);
      else if (!w_set && w_wb_hit) w_count_nxt = r_count - CNT_W'(1);
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_busy     <= '0;
         r_count    <= '0;
         r_wb_error <= 1'b0;
      end else if (sb.flush) begin
         r_busy  <= '0;
         r_count <= '0;
      end else begin
         r_busy  <= w_busy_nxt;
         r_count <= w_count_nxt;
         if (w_wb_bad) r_wb_error <= 1'b1;
      end
   end

   assign sb.issue_ready    = w_ready;
   assign sb.busy_mask      = w_busy;
   assign sb.inflight_count = r_count;
   assign sb.wb_error       = r_wb_error;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven bench for regfile_scoreboard: combinational outputs checked mid-cycle,
// registered outputs checked through an expected-result queue after each edge.
module tb_regfile_scoreboard;
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   regfile_scoreboard_if #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(3)) sb_if ();

   regfile_scoreboard dut (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .sb        (sb_if)
   );

   typedef struct {
      logic        v;
      logic [4:0]  rs1;
      logic        u1;
      logic [4:0]  rs2;
      logic        u2;
      logic [4:0]  rd;
      logic        wr;
      logic        wbv;
      logic [4:0]  wbrd;
      logic        fl;
      logic        rstn;
      logic        e_rdy;
      logic [1:0]  e_stall;
      logic [31:0] e_busy;
      logic [2:0]  e_cnt;
      logic        e_err;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] busy;
      logic [2:0]  cnt;
      logic        err;
   } post_t;

   vec_t  tv[$];
   post_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic wr, input logic wbv, input logic [4:0] wbrd,
                      input logic fl, input logic rstn, input logic e_rdy,
                      input logic [1:0] e_stall, input logic [31:0] e_busy,
                      input logic [2:0] e_cnt, input logic e_err);
      vec_t t;
      t = '{v, rs1, u1, rs2, u2, rd, wr, wbv, wbrd, fl, rstn,
            e_rdy, e_stall, e_busy, e_cnt, e_err};
      tv.push_back(t);
   endtask

   task automatic drive(input vec_t t);
      sb_if.issue_valid     = t.v;
      sb_if.issue_rs1       = t.rs1;
      sb_if.issue_uses_rs1  = t.u1;
      sb_if.issue_rs2       = t.rs2;
      sb_if.issue_uses_rs2  = t.u2;
      sb_if.issue_rd        = t.rd;
      sb_if.issue_writes_rd = t.wr;
      sb_if.wb_valid        = t.wbv;
      sb_if.wb_rd           = t.wbrd;
      sb_if.flush           = t.fl;
      reset_n               = t.rstn;
   endtask

   task automatic idle();
      vec_t t;
      t = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1,
            1'b1, 2'd0, 32'h0, 3'd0, 1'b0};
      drive(t);
   endtask

   task automatic check_post();
      post_t p;
      if (exp_q.size() == 0) begin
         chk("queue_empty", -1, 32'd1, 32'd0);
      end else begin
         p = exp_q.pop_front();
         chk("busy_mask", p.idx, sb_if.busy_mask, p.busy);
         chk("inflight_count", p.idx, 32'(sb_if.inflight_count), 32'(p.cnt));
         chk("wb_error", p.idx, 32'(sb_if.wb_error), 32'(p.err));
         chk("invariant", p.idx, 32'($countones(sb_if.busy_mask)),
             32'(sb_if.inflight_count));
      end
   endtask

   initial begin
      post_t p;
      int    n;
      //     v  rs1 u1 rs2 u2 rd  wr wbv wbrd fl rn  rdy st busy          cnt err
      add(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1,   1, 0, 32'h0000_0020, 1, 0);
      add(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1,   0, 1, 32'h0000_0020, 1, 0);
      add(1, 5, 1, 0, 0, 6, 1, 1, 5, 0, 1,   0, 1, 32'h0000_0000, 0, 0);
      add(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1,   1, 0, 32'h0000_0040, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 1,   1, 0, 32'h0000_0000, 0, 0);
      add(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1,   1, 0, 32'h0000_0008, 1, 0);
      add(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1,   1, 0, 32'h0000_0018, 2, 0);
      add(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 1,   1, 0, 32'h0000_0058, 3, 0);
      add(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1,   1, 0, 32'h0000_00D8, 4, 0);
      add(1, 0, 0, 0, 0, 8, 1, 1, 3, 0, 1,   0, 3, 32'h0000_00D0, 3, 0);
      add(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 1,   1, 0, 32'h0000_01D0, 4, 0);
      add(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1,   1, 0, 32'h0000_01D0, 4, 0);
      add(1, 0, 0, 0, 0, 9, 1, 1, 4, 1, 1,   0, 0, 32'h0000_0000, 0, 0);
      add(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1,   1, 0, 32'h0000_0000, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,   1, 0, 32'h0000_0000, 0, 0);
      add(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 1,   1, 0, 32'h0000_0200, 1, 0);
      add(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 1,   0, 2, 32'h0000_0200, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 1,  1, 0, 32'h0000_0200, 1, 1);
      add(1, 9, 1, 0, 0, 9, 1, 0, 0, 0, 1,   0, 1, 32'h0000_0200, 1, 1);
      add(1, 0, 0, 0, 0, 10, 1, 1, 9, 0, 1,  1, 0, 32'h0000_0400, 1, 1);
      add(1, 0, 0, 9, 1, 11, 1, 0, 0, 0, 1,  1, 0, 32'h0000_0C00, 2, 1);
      add(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 1,  1, 0, 32'h0000_1C00, 3, 1);
      add(1, 0, 0, 0, 0, 13, 1, 1, 10, 1, 1, 0, 0, 32'h0000_0000, 0, 1);
      add(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 1,  1, 0, 32'h0000_4000, 1, 1);
      add(1, 0, 0, 0, 0, 15, 1, 1, 14, 0, 0, 1, 0, 32'h0000_0000, 0, 0);
      add(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1,   1, 0, 32'h0000_0002, 1, 0);

      idle();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      p = '{-1, 32'h0, 3'd0, 1'b0};
      exp_q.push_back(p);
      check_post();

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clock);
         drive(tv[i]);
         #1;
         chk("issue_ready", i, 32'(sb_if.issue_ready), 32'(tv[i].e_rdy));
         chk("stall_cause", i, 32'(sb_if.stall_cause), 32'(tv[i].e_stall));
         p = '{i, tv[i].e_busy, tv[i].e_cnt, tv[i].e_err};
         exp_q.push_back(p);
         @(posedge clock);
         #1;
         check_post();
      end

      // Writeback of a source in cycle N keeps it stalled in N; it must release in N+1.
      @(negedge clock);
      idle();
      sb_if.issue_valid = 1'b1; sb_if.issue_rd = 5'd20; sb_if.issue_writes_rd = 1'b1;
      @(posedge clock);
      #1;
      chk("seq_busy20", 100, sb_if.busy_mask, 32'h0010_0002);
      @(negedge clock);
      sb_if.issue_rs1 = 5'd20; sb_if.issue_uses_rs1 = 1'b1; sb_if.issue_rd = 5'd21;
      sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd20;
      #1;
      chk("seq_nobypass", 101, 32'(sb_if.issue_ready), 32'd0);
      @(posedge clock);
      n = 0;
      while (n < 5) begin
         @(negedge clock);
         sb_if.wb_valid = 1'b0;
         #1;
         if (sb_if.issue_ready) break;
         n++;
      end
      chk("seq_release_cycles", 102, 32'(n), 32'd0);
      @(posedge clock);
      #1;
      chk("seq_busy21", 103, sb_if.busy_mask, 32'h0020_0002);
      chk("seq_cnt", 104, 32'(sb_if.inflight_count), 32'd2);
      @(negedge clock);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
